fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_if.sv | 32 +++
 rtl/fetch_ctrl.sv | 77 +++++++
 tb/tb_fetch_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: program counter, memory, decoder and redirect signals of the fetch controller
interface fetch_ctrl_if;
  logic [15:0] pc_count;
  logic        pc_ld;
  logic        pc_inc;
  logic [15:0] pc_din;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic        mem_rd_ack;
  logic [7:0]  mem_dout;
  logic        ir_valid;
  logic [7:0]  ir_data;
  logic        ir_ready;
  logic        br_valid;
  logic        br_rel;
  logic [15:0] br_addr;
  logic [7:0]  br_offs;
  logic        int_req;
  logic [2:0]  int_vec;
  logic        int_ack;
  logic        halt;
  modport master (
    input  pc_count, mem_rd_ack, mem_dout, ir_ready, br_valid, br_rel, br_addr, br_offs,
           int_req, int_vec, halt,
    output pc_ld, pc_inc, pc_din, mem_rd_req, mem_addr, ir_valid, ir_data, int_ack
  );
  modport slave (
    output pc_count, mem_rd_ack, mem_dout, ir_ready, br_valid, br_rel, br_addr, br_offs,
           int_req, int_vec, halt,
    input  pc_ld, pc_inc, pc_din, mem_rd_req, mem_addr, ir_valid, ir_data, int_ack
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: byte fetch sequencer driving an external program counter, with branch, interrupt and halt handling
module fetch_ctrl #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] INT_BASE     = 16'h0040
) (
  input logic         fc_clk,
  input logic         fc_rst_n,
  fetch_ctrl_if.master bus
);
  typedef enum logic [1:0] {LOAD, REQ, HOLD, HALTED} state_t;
  state_t      state, state_nxt;
  logic        ir_valid, ir_valid_nxt, halt_pend, halt_pend_nxt;
  logic [7:0]  ir_data;
  logic        req, int_ok, halting, capture, pc_ld, pc_inc, int_ack;
  logic [15:0] pc_din, br_tgt, int_tgt;
  always_comb begin
    req = state == REQ && (!ir_valid || bus.ir_ready);
    br_tgt = bus.br_rel ? bus.pc_count + {{8{bus.br_offs[7]}}, bus.br_offs} : bus.br_addr;
    int_tgt = INT_BASE + {10'd0, bus.int_vec, 3'd0};
    int_ok = bus.int_req && bus.int_vec <= 3'd4 && !bus.br_valid && (!ir_valid || bus.ir_ready);
    halting = bus.halt || halt_pend;
    state_nxt = state;
    ir_valid_nxt = ir_valid;
    halt_pend_nxt = halt_pend;
    capture = 1'b0;
    pc_ld = 1'b0;
    pc_inc = 1'b0;
    pc_din = '0;
    int_ack = 1'b0;
    if (state == LOAD) begin
      pc_ld = 1'b1;
      pc_din = RESET_VECTOR;
      state_nxt = REQ;
    end else if (bus.br_valid || int_ok) begin
      pc_ld = 1'b1;
      pc_din = bus.br_valid ? br_tgt : int_tgt;
      int_ack = !bus.br_valid;
      state_nxt = REQ;
      ir_valid_nxt = 1'b0;
      halt_pend_nxt = 1'b0;
    end else if (halting && state != HALTED) begin
      // an in-flight read must see its ack before halting; the fetched byte is dropped
      halt_pend_nxt = req && !bus.mem_rd_ack;
      ir_valid_nxt = 1'b0;
      state_nxt = (req && !bus.mem_rd_ack) ? REQ : HALTED;
    end else if (state == HOLD) begin
      state_nxt = bus.ir_ready ? REQ : HOLD;
      ir_valid_nxt = !bus.ir_ready;
    end else if (state == REQ) begin
      capture = req && bus.mem_rd_ack;
      pc_inc = capture;
      ir_valid_nxt = capture || (ir_valid && !bus.ir_ready);
      state_nxt = (ir_valid && !bus.ir_ready) ? HOLD : REQ;
    end
  end
  always_ff @(posedge fc_clk or negedge fc_rst_n)
    if (!fc_rst_n) begin
      state <= LOAD;
      ir_valid <= 1'b0;
      ir_data <= '0;
      halt_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      ir_valid <= ir_valid_nxt;
      halt_pend <= halt_pend_nxt;
      if (capture) ir_data <= bus.mem_dout;
    end
  // reset forces every output low without waiting for a clock
  assign bus.pc_ld      = fc_rst_n && pc_ld;
  assign bus.pc_inc     = fc_rst_n && pc_inc;
  assign bus.pc_din     = fc_rst_n ? pc_din : '0;
  assign bus.mem_rd_req = fc_rst_n && req;
  assign bus.mem_addr   = fc_rst_n ? bus.pc_count : '0;
  assign bus.int_ack    = fc_rst_n && int_ack;
  assign bus.ir_valid   = ir_valid;
  assign bus.ir_data    = ir_data;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random fetch traffic checked against a cycle reference model
module tb_fetch_ctrl;
  localparam logic [15:0] RV = 16'h0100;
  localparam logic [15:0] IB = 16'h0040;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] pc = 16'h0000;
  int total = 0, bad = 0;
  logic s_br = 0, s_rel = 0, s_int = 0, s_halt = 0, s_rdy = 1, s_ack = 1;
  logic [15:0] s_ba = 0;
  logic [7:0] s_bo = 0;
  logic [2:0] s_iv = 0;
  logic m_started = 0, m_valid = 0, m_stalled = 0, m_halted = 0, m_hpend = 0;
  logic [7:0] m_data = 0;
  logic [15:0] m_pc = 0;
  fetch_ctrl_if bus();
  fetch_ctrl #(.RESET_VECTOR(RV), .INT_BASE(IB)) dut (.fc_clk(clk), .fc_rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  function automatic logic [7:0] mdata(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA4;
  endfunction
  assign bus.pc_count = pc;
  assign bus.mem_dout = mdata(bus.mem_addr);
  always @(posedge clk)
    if (bus.pc_ld) pc <= bus.pc_din;
    else if (bus.pc_inc) pc <= pc + 16'd1;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    logic e_ld, e_inc, e_iack, e_req, bnd, iok;
    logic [15:0] e_din;
    @(negedge clk);
    bus.br_valid = s_br; bus.br_rel = s_rel; bus.br_addr = s_ba; bus.br_offs = s_bo;
    bus.int_req = s_int; bus.int_vec = s_iv; bus.halt = s_halt;
    bus.ir_ready = s_rdy; bus.mem_rd_ack = s_ack;
    s_br = 0; s_halt = 0;
    #1;
    chk("pc", pc, m_pc);
    chk("ir_valid", bus.ir_valid, m_valid);
    if (m_valid) chk("ir_data", bus.ir_data, m_data);
    if (m_started) chk("mem_addr", bus.mem_addr, m_pc);
    e_ld = 0; e_inc = 0; e_iack = 0; e_din = 0;
    e_req = m_started && !m_halted && (!m_valid || (s_rdy && !m_stalled));
    bnd = !m_valid || s_rdy;
    iok = bus.int_req && bus.int_vec <= 3'd4 && !bus.br_valid && bnd;
    if (!m_started) begin
      e_ld = 1; e_din = RV; m_started = 1;
    end else if (bus.br_valid || iok) begin
      e_ld = 1;
      e_din = bus.br_valid ? (bus.br_rel ? m_pc + 16'($signed(bus.br_offs)) : bus.br_addr)
                           : IB + 16'(bus.int_vec) * 16'd8;
      e_iack = !bus.br_valid;
      m_valid = 0; m_stalled = 0; m_halted = 0; m_hpend = 0;
    end else if (m_halted) begin
      m_valid = 0;
    end else if (bus.halt || m_hpend) begin
      if (e_req && !bus.mem_rd_ack) m_hpend = 1;
      else begin m_halted = 1; m_hpend = 0; end
      m_valid = 0; m_stalled = 0;
    end else if (e_req && bus.mem_rd_ack) begin
      e_inc = 1; m_valid = 1; m_data = mdata(m_pc); m_stalled = 0;
    end else if (m_valid && !s_rdy) begin
      m_stalled = 1;
    end else begin
      m_valid = 0; m_stalled = 0;
    end
    chk("pc_ld", bus.pc_ld, e_ld);
    chk("pc_inc", bus.pc_inc, e_inc);
    if (e_ld) chk("pc_din", bus.pc_din, e_din);
    chk("mem_rd_req", bus.mem_rd_req, e_req);
    chk("int_ack", bus.int_ack, e_iack);
    if (e_ld) m_pc = e_din;
    else if (e_inc) m_pc = m_pc + 16'd1;
  endtask
  initial begin
    bus.br_valid = 0; bus.br_rel = 0; bus.br_addr = 0; bus.br_offs = 0; bus.int_req = 0;
    bus.int_vec = 0; bus.halt = 0; bus.ir_ready = 0; bus.mem_rd_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_ld", bus.pc_ld, 0);
    chk("rst_pc_inc", bus.pc_inc, 0);
    chk("rst_pc_din", bus.pc_din, 0);
    chk("rst_req", bus.mem_rd_req, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_ir_valid", bus.ir_valid, 0);
    chk("rst_int_ack", bus.int_ack, 0);
    rst_n = 1;
    step(); chk("boot_ld", bus.pc_ld, 1); chk("boot_din", bus.pc_din, 16'h0100);
    step(); chk("boot_addr", bus.mem_addr, 16'h0100);
    step(); chk("boot_valid", bus.ir_valid, 1); chk("boot_data", bus.ir_data, 16'h00A5);
    chk("boot_pc", pc, 16'h0101);
    s_rdy = 0;
    repeat (3) begin
      step(); chk("hold_req", bus.mem_rd_req, 0); chk("hold_data", bus.ir_data, 16'h00A4);
    end
    s_rdy = 1;
    step(); chk("hold_exit_req", bus.mem_rd_req, 0);
    step(); chk("resume_req", bus.mem_rd_req, 1);
    s_br = 1; s_ba = 16'h0150; step();
    s_br = 1; s_rel = 1; s_bo = 8'hFE; step();
    chk("rel_din", bus.pc_din, 16'h014E); chk("rel_inc", bus.pc_inc, 0);
    s_rel = 0;
    step(); chk("rel_valid", bus.ir_valid, 0); chk("rel_pc", pc, 16'h014E);
    s_br = 1; s_ba = 16'h2000; s_int = 1; s_iv = 3'd2; step();
    chk("brint_din", bus.pc_din, 16'h2000); chk("brint_ack", bus.int_ack, 0);
    step(); chk("int_ack", bus.int_ack, 1); chk("int_din", bus.pc_din, 16'h0050);
    s_int = 0;
    step(); chk("int_pc", pc, 16'h0050);
    s_halt = 1; s_ack = 0; step();
    s_ack = 1; step();
    repeat (10) begin
      step(); chk("halted_req", bus.mem_rd_req, 0); chk("halted_valid", bus.ir_valid, 0);
    end
    s_int = 1; s_iv = 3'd0; step();
    chk("wake_din", bus.pc_din, 16'h0040); chk("wake_ack", bus.int_ack, 1);
    s_int = 0;
    step(); chk("wake_req", bus.mem_rd_req, 1); chk("wake_addr", bus.mem_addr, 16'h0040);
    s_halt = 1; s_br = 1; s_ba = 16'h3000; step();
    step(); chk("brhalt_req", bus.mem_rd_req, 1);
    s_int = 1; s_iv = 3'd5; step();
    chk("vec5_ack", bus.int_ack, 0); chk("vec5_ld", bus.pc_ld, 0);
    s_int = 0;
    s_br = 1; s_ba = 16'hFFFF; step();
    step(); chk("wrap_inc", bus.pc_inc, 1); chk("wrap_addr0", bus.mem_addr, 16'hFFFF);
    step(); chk("wrap_pc", pc, 16'h0000); chk("wrap_addr", bus.mem_addr, 16'h0000);
    for (int i = 0; i < 1500; i++) begin
      s_br = ($urandom_range(15) == 0);
      s_rel = 1'($urandom);
      s_ba = 16'($urandom);
      s_bo = 8'($urandom);
      s_int = ($urandom_range(7) == 0);
      s_iv = 3'($urandom_range(7));
      s_halt = ($urandom_range(31) == 0);
      s_rdy = ($urandom_range(3) != 0);
      s_ack = 1'($urandom);
      step();
    end
    s_int = 0; s_rdy = 1;
    s_br = 1; s_rel = 0; s_ba = 16'h1234; step();
    s_ack = 0; step(); chk("pre_rst_req", bus.mem_rd_req, 1);
    #1 rst_n = 0;
    #1;
    chk("midrst_req", bus.mem_rd_req, 0);
    chk("midrst_addr", bus.mem_addr, 0);
    chk("midrst_valid", bus.ir_valid, 0);
    chk("midrst_ld", bus.pc_ld, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
